// File: rtl/sprite_pkg.sv
// Shared constants for the sprite compositor: colours, sprite bitmaps, projectile
// extents, event-channel states and the rectangle test helper.
package sprite_pkg;

   localparam int COORD_W = 10;

   localparam logic [7:0] COLOR_BLACK = 8'h00;
   localparam logic [7:0] COLOR_GREEN = 8'h1C;
   localparam logic [7:0] COLOR_WHITE = 8'hFF;

   // Bitmaps are packed row-major: bit y*W+x, x=0 is the leftmost pixel.
   localparam int PLAYER_W = 8;
   localparam int PLAYER_H = 8;
   localparam logic [63:0] PLAYER = 64'hFFFF_FFFF_7E3C_1818;

   localparam int INVADER1_W = 8;
   localparam int INVADER1_H = 8;
   localparam logic [63:0] INVADER1 = 64'hA55A_24FF_DB7E_3C99;

   localparam int LASER_W   = 2;
   localparam int LASER_H   = 8;
   localparam int MISSILE_W = 2;
   localparam int MISSILE_H = 8;

   typedef enum logic {
      EVT_IDLE    = 1'b0,
      EVT_PENDING = 1'b1
   } evt_state_t;

   function automatic logic rect_hit(input logic [COORD_W-1:0] pix,
                                     input logic [COORD_W-1:0] org,
                                     input logic [COORD_W:0]   ext);
      logic [COORD_W:0] d;
      d = {1'b0, pix} - {1'b0, org};
      return (pix >= org) && (d < ext);
   endfunction

endpackage

// File: rtl/sprite_bitmap_lookup.sv
// Registered bitmap fetch: latches the bitmap address and in-range flag, then
// reads the selected bitmap bit from the registered address.
module sprite_bitmap_lookup #(
   parameter int BMP_W = 8,
   parameter int BMP_H = 8,
   parameter logic [BMP_W*BMP_H-1:0] BITMAP = '0
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(BMP_W)-1:0]   addr_x,
   input  logic [$clog2(BMP_H)-1:0]   addr_y,
   input  logic                       in_range,
   output logic                       pix
);

   localparam int AXW = $clog2(BMP_W);
   localparam int AYW = $clog2(BMP_H);
   localparam int NB  = BMP_W * BMP_H;
   localparam int IW  = $clog2(NB);

   logic [AXW-1:0] addr_x_q;
   logic [AYW-1:0] addr_y_q;
   logic           in_range_q;
   logic [IW-1:0]  idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_x_q   <= '0;
         addr_y_q   <= '0;
         in_range_q <= 1'b0;
      end else begin
         addr_x_q   <= addr_x;
         addr_y_q   <= addr_y;
         in_range_q <= in_range;
      end
   end

   assign idx = IW'(addr_y_q) * IW'(BMP_W) + IW'(addr_x_q);
   assign pix = in_range_q & (|(BITMAP & (NB'(1) << idx)));

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite mixer: player, laser, missiles and invader grid with layer
// priority, plus latched ack-handshaked collision events.
//
// Event channel states (index 0 = invader, 1 = player):
//   state       | meaning
//   EVT_IDLE    | no event held, valid=0
//   EVT_PENDING | event payload held, valid=1 until ack
module sprite_compositor
   import sprite_pkg::*;
#(
   parameter int NUM_MISSILES = 3,
   parameter int INV_ROWS     = 5,
   parameter int INV_COLS     = 11,
   parameter int SCALE_LOG2   = 1,
   parameter int PITCH_X_LOG2 = 5,
   parameter int PITCH_Y_LOG2 = 5,
   parameter int COLOR_W      = 8
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            data_enable,
   input  logic                            frame,
   input  logic [9:0]                      pixel_x,
   input  logic [9:0]                      pixel_y,
   input  logic [9:0]                      player_x,
   input  logic [9:0]                      player_y,
   input  logic                            laser_active,
   input  logic [9:0]                      laser_x,
   input  logic [9:0]                      laser_y,
   input  logic [NUM_MISSILES-1:0]         missile_active,
   input  logic [10*NUM_MISSILES-1:0]      missile_x,
   input  logic [10*NUM_MISSILES-1:0]      missile_y,
   input  logic [INV_ROWS*INV_COLS-1:0]    invaders,
   input  logic [9:0]                      invaders_x,
   input  logic [9:0]                      invaders_y,
   output logic [COLOR_W-1:0]              vga_out,
   output logic                            inv_hit_valid,
   output logic [2:0]                      inv_hit_row,
   output logic [3:0]                      inv_hit_col,
   input  logic                            inv_hit_ack,
   output logic                            player_hit_valid,
   input  logic                            player_hit_ack,
   output logic                            hit_overflow
);

   localparam int CW    = COORD_W + 1;
   localparam int CELLS = INV_ROWS * INV_COLS;
   localparam int PAXW  = $clog2(PLAYER_W);
   localparam int PAYW  = $clog2(PLAYER_H);
   localparam int IAXW  = $clog2(INVADER1_W);
   localparam int IAYW  = $clog2(INVADER1_H);

   localparam logic [CW-1:0] PLAYER_EXT_X  = CW'(PLAYER_W << SCALE_LOG2);
   localparam logic [CW-1:0] PLAYER_EXT_Y  = CW'(PLAYER_H << SCALE_LOG2);
   localparam logic [CW-1:0] INV_EXT_X     = CW'(INVADER1_W << SCALE_LOG2);
   localparam logic [CW-1:0] INV_EXT_Y     = CW'(INVADER1_H << SCALE_LOG2);
   localparam logic [CW-1:0] LASER_EXT_X   = CW'(LASER_W);
   localparam logic [CW-1:0] LASER_EXT_Y   = CW'(LASER_H);
   localparam logic [CW-1:0] MISSILE_EXT_X = CW'(MISSILE_W);
   localparam logic [CW-1:0] MISSILE_EXT_Y = CW'(MISSILE_H);

   // ---------------- stage 1: geometry ----------------
   logic [CW-1:0]           player_dx, player_dy;
   logic                    player_in;
   logic [CW-1:0]           inv_dx, inv_dy, inv_col, inv_row;
   logic [PITCH_X_LOG2-1:0] inv_lx;
   logic [PITCH_Y_LOG2-1:0] inv_ly;
   logic                    inv_in, alive;
   logic [6:0]              cell_idx;
   logic                    laser_hit;
   logic [NUM_MISSILES-1:0] missile_hit;

   assign player_dx = {1'b0, pixel_x} - {1'b0, player_x};
   assign player_dy = {1'b0, pixel_y} - {1'b0, player_y};
   assign player_in = rect_hit(pixel_x, player_x, PLAYER_EXT_X) &&
                      rect_hit(pixel_y, player_y, PLAYER_EXT_Y);

   assign laser_hit = laser_active && rect_hit(pixel_x, laser_x, LASER_EXT_X) &&
                      rect_hit(pixel_y, laser_y, LASER_EXT_Y);

   for (genvar i = 0; i < NUM_MISSILES; i++) begin : g_missile
      assign missile_hit[i] = missile_active[i] &&
         rect_hit(pixel_x, missile_x[10*i +: 10], MISSILE_EXT_X) &&
         rect_hit(pixel_y, missile_y[10*i +: 10], MISSILE_EXT_Y);
   end

   assign inv_dx  = {1'b0, pixel_x} - {1'b0, invaders_x};
   assign inv_dy  = {1'b0, pixel_y} - {1'b0, invaders_y};
   assign inv_col = inv_dx >> PITCH_X_LOG2;
   assign inv_row = inv_dy >> PITCH_Y_LOG2;
   assign inv_lx  = inv_dx[PITCH_X_LOG2-1:0];
   assign inv_ly  = inv_dy[PITCH_Y_LOG2-1:0];
   assign inv_in  = (pixel_x >= invaders_x) && (pixel_y >= invaders_y) &&
                    (inv_col < CW'(INV_COLS)) && (inv_row < CW'(INV_ROWS)) &&
                    (CW'(inv_lx) < INV_EXT_X) && (CW'(inv_ly) < INV_EXT_Y);

   // Index is only meaningful while inv_in holds; alive is gated accordingly.
   assign cell_idx = 7'(inv_row) * 7'(INV_COLS) + 7'(inv_col);
   assign alive    = inv_in & (|(invaders & (CELLS'(1) << cell_idx)));

   logic       de_q, laser_q, missile_q, alive_q;
   logic [2:0] inv_row_q;
   logic [3:0] inv_col_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         de_q      <= 1'b0;
         laser_q   <= 1'b0;
         missile_q <= 1'b0;
         alive_q   <= 1'b0;
         inv_row_q <= '0;
         inv_col_q <= '0;
      end else begin
         de_q      <= data_enable;
         laser_q   <= laser_hit;
         missile_q <= |missile_hit;
         alive_q   <= alive;
         inv_row_q <= 3'(inv_row);
         inv_col_q <= 4'(inv_col);
      end
   end

   logic player_pix, inv_bmp_pix;

   sprite_bitmap_lookup #(
      .BMP_W (PLAYER_W),
      .BMP_H (PLAYER_H),
      .BITMAP(PLAYER)
   ) u_player_bmp (
      .clk     (clk),
      .rst     (rst),
      .addr_x  (PAXW'(player_dx >> SCALE_LOG2)),
      .addr_y  (PAYW'(player_dy >> SCALE_LOG2)),
      .in_range(player_in),
      .pix     (player_pix)
   );

   sprite_bitmap_lookup #(
      .BMP_W (INVADER1_W),
      .BMP_H (INVADER1_H),
      .BITMAP(INVADER1)
   ) u_invader_bmp (
      .clk     (clk),
      .rst     (rst),
      .addr_x  (IAXW'(inv_lx >> SCALE_LOG2)),
      .addr_y  (IAYW'(inv_ly >> SCALE_LOG2)),
      .in_range(inv_in),
      .pix     (inv_bmp_pix)
   );

   // ---------------- stage 2: compose and detect ----------------
   logic       inv_pix, inv_evt, player_evt;
   logic [7:0] pix_color;

   assign inv_pix    = inv_bmp_pix & alive_q;
   assign inv_evt    = de_q & laser_q & inv_pix;
   assign player_evt = de_q & missile_q & player_pix;

   always_comb begin
      pix_color = COLOR_BLACK;
      if (!de_q)                  pix_color = COLOR_BLACK;
      else if (player_pix)        pix_color = COLOR_GREEN;
      else if (laser_q | missile_q) pix_color = COLOR_WHITE;
      else if (inv_pix)           pix_color = COLOR_WHITE;
   end

   always_ff @(posedge clk) begin
      if (rst) vga_out <= '0;
      else     vga_out <= COLOR_W'(pix_color);
   end

   evt_state_t ch_state    [2];
   evt_state_t ch_state_nx [2];
   logic [1:0] armed, armed_nx, evt, ack, capture, drop;

   assign evt = {player_evt, inv_evt};
   assign ack = {player_hit_ack, inv_hit_ack};

   // frame re-arms before the same-cycle event is considered; any event seen
   // while armed (captured or dropped) consumes the arm for this frame.
   always_comb begin
      logic arm_eff;
      arm_eff  = 1'b0;
      armed_nx = armed;
      capture  = '0;
      drop     = '0;
      for (int i = 0; i < 2; i++) begin
         ch_state_nx[i] = ch_state[i];
         arm_eff        = armed[i] | frame;
         capture[i]     = evt[i] & arm_eff & ((ch_state[i] == EVT_IDLE) | ack[i]);
         drop[i]        = evt[i] & arm_eff & (ch_state[i] == EVT_PENDING) & ~ack[i];
         armed_nx[i]    = arm_eff & ~evt[i];
         if (capture[i])  ch_state_nx[i] = EVT_PENDING;
         else if (ack[i]) ch_state_nx[i] = EVT_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_state     <= '{EVT_IDLE, EVT_IDLE};
         armed        <= 2'b11;
         inv_hit_row  <= '0;
         inv_hit_col  <= '0;
         hit_overflow <= 1'b0;
      end else begin
         ch_state <= ch_state_nx;
         armed    <= armed_nx;
         if (capture[0]) begin
            inv_hit_row <= inv_row_q;
            inv_hit_col <= inv_col_q;
         end
         if (|drop) hit_overflow <= 1'b1;
      end
   end

   assign inv_hit_valid    = (ch_state[0] == EVT_PENDING);
   assign player_hit_valid = (ch_state[1] == EVT_PENDING);

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised successor of the current single-frame VGA sprite mixer; sits between `vga_timings` and the VGA DAC. It draws the player, the laser, N enemy missiles and an R×C invader grid with layer priority, using a 2-stage pipeline. It detects laser/invader and missile/player collisions on drawn pixels. Each collision is reported as a latched, ack-handshaked event carrying row/col, in place of a one-cycle pulse.

## Interface
- `NUM_MISSILES`, 3, number of enemy missile channels (1..8)
- `INV_ROWS`, 5, invader grid rows (1..8)
- `INV_COLS`, 11, invader grid columns (1..16)
- `SCALE_LOG2`, 1, sprite pixel magnification = 2^SCALE_LOG2
- `PITCH_X_LOG2`, 5, horizontal invader cell pitch = 2^PITCH_X_LOG2 screen pixels
- `PITCH_Y_LOG2`, 5, vertical invader cell pitch
- `COLOR_W`, 8, pixel colour width
- `clk` in 1: pixel clock
- `rst` in 1: synchronous, active-high reset
- `data_enable` in 1: active-video qualifier from `vga_timings`
- `frame` in 1: one-cycle start-of-blanking pulse
- `pixel_x`, `pixel_y` in 10 each: current pixel
- `player_x`, `player_y` in 10 each: player sprite origin
- `laser_active` in 1; `laser_x`, `laser_y` in 10 each
- `missile_active` in NUM_MISSILES; `missile_x`, `missile_y` in 10*NUM_MISSILES each: packed, channel i at [10i+9:10i]
- `invaders` in INV_ROWS*INV_COLS: alive mask, bit r*INV_COLS+c
- `invaders_x`, `invaders_y` in 10 each: grid origin
- `vga_out` out COLOR_W: composited pixel
- `inv_hit_valid` out 1; `inv_hit_row` out 3; `inv_hit_col` out 4; `inv_hit_ack` in 1
- `player_hit_valid` out 1; `player_hit_ack` in 1
- `hit_overflow` out 1: sticky, an event was dropped

## Operation
- Stage 1 (registered):
  - Rectangle tests for player, laser and each active missile. Compare in 11 bits: hit when `pixel >= origin` and `pixel - origin < extent`.
  - Grid test: `dx = pixel_x - invaders_x`, `col = dx >> PITCH_X_LOG2`, `lx = dx[PITCH_X_LOG2-1:0]`, likewise for row/ly. Cell valid only when `dx`,`dy` are non-negative, `col < INV_COLS`, `row < INV_ROWS`, and `lx`,`ly` lie within the sprite extent.
  - Registers bitmap addresses `lx >> SCALE_LOG2`, `ly >> SCALE_LOG2`, plus `row`, `col` and the alive bit.
- Stage 2:
  - Bitmap lookup: player hit requires bitmap bit set; invader hit requires bitmap bit set and alive.
  - Priority: player GREEN > laser/missile WHITE > invader WHITE > 0. Output 0 whenever delayed `data_enable` = 0.
- Collisions, evaluated in stage 2 on qualified pixels:
  - laser ∧ invader → invader event carrying `row`,`col`.
  - any missile ∧ player → player event.
- Event capture, one independent channel each for invader and player:
  - An armed flag permits only the first event per frame to be captured. `frame` re-arms the channel.
  - States: IDLE (valid=0) → PENDING (valid=1, payload held) on a captured event; PENDING → IDLE on ack.
  - Event while PENDING: drop it and set `hit_overflow`. Event while disarmed: ignore.
  - ack and new capturable event in the same cycle: valid stays 1, new payload loaded.
  - `frame` and event in the same cycle: re-arm first, then capture.
  - ack while IDLE: no effect.
- Reset: all outputs 0, channels IDLE and armed, pipeline flushed. This also applies to reset mid-frame or mid-pending.

## Timing
- `vga_out` lags `pixel_x/y`/`data_enable` by exactly 2 cycles. `vga_timings` compensates the sync lag by 2.
- Event valid asserts 2 cycles after the colliding pixel.
- The ack is sampled on the clock edge. Valid deasserts the cycle after the ack.
- Sprite origins and `invaders` are sampled each cycle. Game logic changes them only in blanking.

## Structure
- Shared package `sprite_pkg`:
  - colour constants
  - sprite bitmaps PLAYER, INVADER1 and their widths/heights
  - projectile extents
  - coordinate width (10)
- Sub-module `sprite_bitmap_lookup`: registered bitmap bit fetch. Used once for the player and once for the invader.
- Missile rectangle tests are generated with a for-generate over NUM_MISSILES.

## Test plan
- Default params, invaders=all-1, origin (100,50), sweep one frame → each cell draws WHITE exactly where the INVADER1 bitmap is set. Pixel (100,50) appears on `vga_out` 2 cycles after being driven.
- Laser at (100,50), bit 0 alive → `inv_hit_valid`=1, row=0, col=0 held until ack. A second overlap in the same frame is ignored.
- Same overlap with bit 0 clear → no event; the pixel draws WHITE via the laser only.
- Missile 2 overlapping the player, no ack across 2 frames → the second frame's event is dropped and `hit_overflow`=1. After ack plus a third frame, a new event is captured.
- Ack and new event in the same cycle at frame start → valid stays 1, payload updates.
- Assert `rst` mid-PENDING → next cycle all outputs 0, and a capture is possible in the same frame.
